// File: rtl/piso4_tx.sv
// ============================================================================
// Module   : piso4_tx
// Purpose  : Parallel-in/serial-out transmitter with one-entry hold buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso4_tx #(
    parameter int WIDTH      = 4,
    parameter int MSB_FIRST  = 1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sdo,
    output logic             sframe,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_full, hold_full_n;
    logic             sdo_q, sdo_n;
    logic             sframe_q, sframe_n;
    logic             done_q, done_n;
    logic             load;
    logic [WIDTH-1:0] load_word;
    logic             xfer;

    // The shift register holds only the bits not yet placed on sdo.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] rest(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    assign load_ready = !hold_full;
    assign xfer       = load_valid && load_ready;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shreg_n     = shreg;
        hold_n      = hold;
        hold_full_n = hold_full;
        sdo_n       = sdo_q;
        sframe_n    = sframe_q;
        done_n      = 1'b0;
        load        = 1'b0;
        load_word   = D;

        case (state)
            IDLE: begin
                if (xfer) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != LAST) begin
                    cnt_n   = cnt + 1'b1;
                    sdo_n   = first_bit(shreg);
                    shreg_n = rest(shreg);
                    if (xfer) begin
                        hold_n      = D;
                        hold_full_n = 1'b1;
                    end
                end else begin
                    done_n = 1'b1;
                    if (hold_full) begin
                        load        = 1'b1;
                        load_word   = hold;
                        hold_full_n = 1'b0;
                    end else if (xfer) begin
                        load = 1'b1;
                    end else begin
                        state_n  = IDLE;
                        sdo_n    = IDLE_LEVEL;
                        sframe_n = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            cnt_n    = '0;
            sdo_n    = first_bit(load_word);
            shreg_n  = rest(load_word);
            sframe_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            sdo_q     <= IDLE_LEVEL;
            sframe_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            sdo_q     <= sdo_n;
            sframe_q  <= sframe_n;
            done_q    <= done_n;
        end
    end

    assign sdo    = sdo_q;
    assign sframe = sframe_q;
    assign done   = done_q;
    assign busy   = (state == SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_piso4_tx.sv
// ============================================================================
// Module   : tb_piso4_tx
// Purpose  : Scoreboard-based bench for piso4_tx (default and LSB-first/idle-0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso4_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] d   = 4'h0;
    logic       load_valid = 1'b0;
    logic       load_ready, sdo, sframe, busy, done;

    logic [3:0] d2 = 4'h0;
    logic       load_valid2 = 1'b0;
    logic       load_ready2, sdo2, sframe2, busy2, done2;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    logic sb[$];

    always #5 clk = ~clk;

    piso4_tx #(.WIDTH(4), .MSB_FIRST(1), .IDLE_LEVEL(1'b1)) u_dut (
        .clk(clk), .rst(rst), .D(d), .load_valid(load_valid),
        .load_ready(load_ready), .sdo(sdo), .sframe(sframe),
        .busy(busy), .done(done)
    );

    piso4_tx #(.WIDTH(4), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .D(d2), .load_valid(load_valid2),
        .load_ready(load_ready2), .sdo(sdo2), .sframe(sframe2),
        .busy(busy2), .done(done2)
    );

    // Expected serial stream for the MSB-first instance.
    task automatic push_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) sb.push_back(w[i]);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (sframe === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_bit: sdo=%b with empty scoreboard at %0t", sdo, $time);
                end else begin
                    logic e;
                    e = sb.pop_front();
                    if (sdo !== e) begin
                        errors++;
                        $display("FAIL sb_bit: sdo=%b expected=%b at %0t", sdo, e, $time);
                    end
                end
            end else if (sdo !== 1'b1) begin
                errors++;
                $display("FAIL idle_level: sdo=%b expected=1 at %0t", sdo, $time);
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1; load_valid = 1'b0; load_valid2 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (sdo !== 1'b1 || sframe !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: sdo=%b sframe=%b busy=%b done=%b ready=%b expected 1 0 0 0 1",
                     sdo, sframe, busy, done, load_ready);
        end
        checks++;
        if (sdo2 !== 1'b0 || sframe2 !== 1'b0 || load_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_state2: sdo2=%b sframe2=%b ready2=%b expected 0 0 1", sdo2, sframe2, load_ready2);
        end
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    task automatic test_single;
        for (int k = 0; k <= 6; k++) begin
            if (k == 0) begin d = 4'b1011; load_valid = 1'b1; end
            else load_valid = 1'b0;
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (load_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL single_ready: ready=%b expected=1", load_ready);
                end
                push_word(4'b1011);
            end else begin
                checks++;
                if (done !== (k == 5) || sframe !== (k <= 4) || busy !== (k <= 4)) begin
                    errors++;
                    $display("FAIL single_c%0d: done=%b sframe=%b busy=%b expected %b %b %b",
                             k, done, sframe, busy, (k == 5), (k <= 4), (k <= 4));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k <= 10; k++) begin
            load_valid = (k <= 1);
            d = (k == 0) ? 4'hA : 4'h5;
            @(negedge clk);
            if (k == 0) push_word(4'hA);
            if (k == 1) push_word(4'h5);
            checks++;
            if (load_ready !== (k < 2 || k >= 5) || sframe !== (k >= 1 && k <= 8) ||
                done !== (k == 5 || k == 9)) begin
                errors++;
                $display("FAIL b2b_c%0d: ready=%b sframe=%b done=%b expected %b %b %b", k,
                         load_ready, sframe, done, (k < 2 || k >= 5), (k >= 1 && k <= 8), (k == 5 || k == 9));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bypass;
        for (int k = 0; k <= 10; k++) begin
            load_valid = (k == 0 || k == 4);
            d = (k == 0) ? 4'hC : 4'h3;
            @(negedge clk);
            if (k == 0) push_word(4'hC);
            if (k == 4) push_word(4'h3);
            checks++;
            if (load_ready !== 1'b1 || sframe !== (k >= 1 && k <= 8) || done !== (k == 5 || k == 9)) begin
                errors++;
                $display("FAIL bypass_c%0d: ready=%b sframe=%b done=%b expected 1 %b %b", k,
                         load_ready, sframe, done, (k >= 1 && k <= 8), (k == 5 || k == 9));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall;
        logic exp_ready;
        for (int k = 0; k <= 14; k++) begin
            load_valid = (k <= 5);
            case (k)
                0:       d = 4'h6;
                1:       d = 4'h9;
                5:       d = 4'h2;
                default: d = 4'($urandom_range(0, 15));
            endcase
            @(negedge clk);
            if (k == 0) push_word(4'h6);
            if (k == 1) push_word(4'h9);
            if (k == 5) push_word(4'h2);
            exp_ready = !((k >= 2 && k <= 4) || (k >= 6 && k <= 8));
            checks++;
            if (load_ready !== exp_ready || sframe !== (k >= 1 && k <= 12) ||
                done !== (k == 5 || k == 9 || k == 13)) begin
                errors++;
                $display("FAIL stall_c%0d: ready=%b sframe=%b done=%b expected %b %b %b", k,
                         load_ready, sframe, done, exp_ready, (k >= 1 && k <= 12), (k == 5 || k == 9 || k == 13));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: %0d bits left, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k <= 8; k++) begin
            load_valid = (k <= 1);
            d = (k == 0) ? 4'hF : 4'h0;
            rst = (k == 2);
            if (k == 3) sb.delete();
            @(negedge clk);
            if (k == 0) push_word(4'hF);
            if (k >= 3) begin
                checks++;
                if (sdo !== 1'b1 || sframe !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL rstmid_c%0d: sdo=%b sframe=%b busy=%b ready=%b done=%b expected 1 0 0 1 0",
                             k, sdo, sframe, busy, load_ready, done);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_params;
        for (int k = 0; k <= 6; k++) begin
            load_valid2 = (k == 0);
            d2 = 4'b0001;
            @(negedge clk);
            checks++;
            if (sdo2 !== (k == 1) || sframe2 !== (k >= 1 && k <= 4) || busy2 !== (k >= 1 && k <= 4) ||
                done2 !== (k == 5) || load_ready2 !== 1'b1) begin
                errors++;
                $display("FAIL params_c%0d: sdo=%b sframe=%b busy=%b done=%b ready=%b expected %b %b %b %b 1",
                         k, sdo2, sframe2, busy2, done2, load_ready2,
                         (k == 1), (k >= 1 && k <= 4), (k >= 1 && k <= 4), (k == 5));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bypass();
        test_stall();
        test_reset_mid();
        test_params();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_drain: %0d bits left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
